data_pipe_rr_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that sits directly upstream of the multi-slaver-to-single-master data_inf interconnect.
- Observes the per-slaver valid/last flags and produces the interconnect's `sw`, `vld_sw` and `prio` controls.
- Keeps one path granted from its first beat until the handshake of its last beat.
- Waits for the interconnect's output to drain before offering `sw` for the next path.

---
 rtl/data_pipe_rr_arbiter_pkg.sv | 20 ++
 rtl/data_pipe_rr_pick.sv | 33 +++
 rtl/data_pipe_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_data_pipe_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_pipe_rr_arbiter_pkg.sv
// Shared types for the data_pipe round-robin arbiter and its interconnect.
// Holds the arbiter state encoding and the path-index width helper.
package data_pipe_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SWITCH,
        LOCK,
        RELEASE
    } arb_state_e;

    function automatic int nsize_of(input int num);
        return (num <= 2)  ? 1 :
               (num <= 4)  ? 2 :
               (num <= 8)  ? 3 :
               (num <= 16) ? 4 : 5;
    endfunction

endpackage

// File: rtl/data_pipe_rr_pick.sv
// Circular first-one search over req, starting at pointer.
// Purely combinational; pointer is assumed to be below NUM.
module data_pipe_rr_pick
    import data_pipe_arb_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int NSIZE = nsize_of(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [NSIZE-1:0] pointer,
    output logic [NSIZE-1:0] index,
    output logic             found
);

    always_comb begin
        int k;
        k     = 0;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            k = int'(pointer) + i;
            // explicit wrap keeps non-power-of-two NUM inside 0..NUM-1
            if (k >= NUM) begin
                k = k - NUM;
            end
            if (!found && req[k]) begin
                found = 1'b1;
                index = NSIZE'(k);
            end
        end
    end

endmodule

// File: rtl/data_pipe_rr_arbiter.sv
// Packet-locked round-robin arbiter driving sw/vld_sw/prio of data_inf.
// Optional lock watchdog enabled by defining DATA_PIPE_ARB_TIMEOUT_EN.
module data_pipe_rr_arbiter
    import data_pipe_arb_pkg::*;
#(
    parameter int NUM     = 8,
    parameter int NSIZE   = nsize_of(NUM),
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [NUM-1:0]   req,
    input  logic [NUM-1:0]   last,
    input  logic             xfer,
    input  logic [NSIZE-1:0] curr_path,
    input  logic             down_idle,
    output logic [NSIZE-1:0] sw,
    output logic             vld_sw,
    output logic [NUM-1:0]   prio,
    output logic             busy,
    output logic             timeout
);

    if (NUM < 2 || NUM > 32 || TIMEOUT < 2) begin : g_bad_param
        $error("data_pipe_rr_arbiter: NUM must be 2..32, TIMEOUT >= 2");
    end

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [NSIZE-1:0] sw_q;
    logic [NSIZE-1:0] sw_d;
    logic [NSIZE-1:0] ptr_q;
    logic [NSIZE-1:0] ptr_d;
    logic [NSIZE-1:0] ptr_next;
    logic [NSIZE-1:0] pick_idx;
    logic             pick_found;
    logic             any_req;
    logic             pkt_end;

    assign any_req  = |req;
    assign pkt_end  = xfer && last[sw_q];
    assign ptr_next = (sw_q == NSIZE'(NUM - 1)) ? '0 : sw_q + NSIZE'(1);

    data_pipe_rr_pick #(
        .NUM   (NUM),
        .NSIZE (NSIZE)
    ) u_pick (
        .req     (req),
        .pointer (ptr_q),
        .index   (pick_idx),
        .found   (pick_found)
    );

`ifdef DATA_PIPE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          to_q;
    logic          to_d;
    logic          cnt_hit;

    assign cnt_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        ptr_d   = ptr_q;
`ifdef DATA_PIPE_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        if (clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = ARB;
                    end
                end
                ARB: begin
                    if (pick_found) begin
                        sw_d    = pick_idx;
                        state_d = SWITCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SWITCH: begin
                    if (curr_path == sw_q) begin
                        state_d = LOCK;
`ifdef DATA_PIPE_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                LOCK: begin
                    if (pkt_end) begin
                        ptr_d   = ptr_next;
                        state_d = RELEASE;
                    end
`ifdef DATA_PIPE_ARB_TIMEOUT_EN
                    else if (xfer) begin
                        cnt_d = '0;
                    end else if (cnt_hit) begin
                        // stalled lock: give the bus away as if last arrived
                        ptr_d   = ptr_next;
                        state_d = RELEASE;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end
                RELEASE: begin
                    if (down_idle) begin
                        state_d = any_req ? ARB : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sw_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef DATA_PIPE_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        prio = '0;
        if (state_q == LOCK) begin
            prio[sw_q] = 1'b1;
        end
    end

    assign sw     = sw_q;
    assign vld_sw = (state_q == LOCK);
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_data_pipe_rr_arbiter.sv
// Directed bench for data_pipe_rr_arbiter (NUM=4 and NUM=5 instances).
// Timeout checks run only when DATA_PIPE_ARB_TIMEOUT_EN is defined.
module tb_data_pipe_rr_arbiter;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       clk_en;

    logic [3:0] req4, last4, prio4;
    logic       xfer4, di4, vld4, busy4, to4;
    logic [1:0] cp4, sw4;

    logic [4:0] req5, last5, prio5;
    logic       xfer5, di5, vld5, busy5, to5;
    logic [2:0] cp5, sw5;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    data_pipe_rr_arbiter #(.NUM(4), .TIMEOUT(16)) u_dut4 (
        .clock     (clock),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .req       (req4),
        .last      (last4),
        .xfer      (xfer4),
        .curr_path (cp4),
        .down_idle (di4),
        .sw        (sw4),
        .vld_sw    (vld4),
        .prio      (prio4),
        .busy      (busy4),
        .timeout   (to4)
    );

    data_pipe_rr_arbiter #(.NUM(5), .TIMEOUT(16)) u_dut5 (
        .clock     (clock),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .req       (req5),
        .last      (last5),
        .xfer      (xfer5),
        .curr_path (cp5),
        .down_idle (di5),
        .sw        (sw5),
        .vld_sw    (vld5),
        .prio      (prio5),
        .busy      (busy5),
        .timeout   (to5)
    );

    // interconnect model: latches sw one cycle later
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cp4 <= '0;
            cp5 <= '0;
        end else begin
            cp4 <= sw4;
            cp5 <= sw5;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_vld4(input string tag);
        int n = 0;
        while (!vld4 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(vld4), 1);
    endtask

    task automatic wait_vld5(input string tag);
        int n = 0;
        while (!vld5 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(vld5), 1);
    endtask

    task automatic beat4(input logic [3:0] l);
        xfer4 = 1'b1;
        last4 = l;
        step();
        xfer4 = 1'b0;
    endtask

    task automatic beat5();
        xfer5 = 1'b1;
        step();
        xfer5 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        clk_en = 1'b1;
        req4   = 4'b1111;
        last4  = 4'b1111;
        xfer4  = 1'b0;
        di4    = 1'b1;
        req5   = '0;
        last5  = 5'b11111;
        xfer5  = 1'b0;
        di5    = 1'b1;

        // reset hold with requests pending
        repeat (3) step();
        chk("rst_sw", 32'(sw4), 0);
        chk("rst_vld", 32'(vld4), 0);
        chk("rst_prio", 32'(prio4), 0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_to", 32'(to4), 0);

        // IDLE -> ARB -> SWITCH -> LOCK in three edges
        rst_n = 1'b1;
        n = 0;
        while (!vld4 && n < 20) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 3);

        // round robin with single-beat packets
        for (int i = 0; i < 5; i++) begin
            wait_vld4("rr");
            chk("rr_sw", 32'(sw4), 32'(i % 4));
            chk("rr_prio", 32'(prio4), 32'(1 << (i % 4)));
            if (i == 1) begin
                repeat (2) step();
                chk("rr_hold_vld", 32'(vld4), 1);
                chk("rr_hold_sw", 32'(sw4), 1);
            end
            beat4(4'b1111);
            chk("rr_rel", 32'(vld4), 0);
        end

        // five-beat packet on path 1 with path 2 waiting
        req4  = 4'b0110;
        last4 = 4'b0100;
        wait_vld4("pk");
        chk("pk_sw", 32'(sw4), 1);
        for (int b = 1; b <= 5; b++) begin
            chk("pk_prio", 32'(prio4), 32'h2);
            if (b == 5) begin
                di4 = 1'b0;
                beat4(4'b0110);
            end else begin
                beat4(4'b0100);
                chk("pk_lock", 32'(vld4), 1);
            end
        end
        repeat (4) step();
        chk("pk_drain_vld", 32'(vld4), 0);
        chk("pk_drain_prio", 32'(prio4), 0);
        chk("pk_drain_busy", 32'(busy4), 1);
        chk("pk_drain_sw", 32'(sw4), 1);
        di4 = 1'b1;
        wait_vld4("pk2");
        chk("pk2_sw", 32'(sw4), 2);
        chk("pk2_prio", 32'(prio4), 32'h4);

        // clk_en low freezes a handshake in LOCK
        clk_en = 1'b0;
        xfer4  = 1'b1;
        last4  = 4'b0100;
        repeat (10) step();
        chk("ce_vld", 32'(vld4), 1);
        chk("ce_sw", 32'(sw4), 2);
        chk("ce_prio", 32'(prio4), 32'h4);
        chk("ce_busy", 32'(busy4), 1);
        req4   = 4'b1001;
        clk_en = 1'b1;
        step();
        xfer4 = 1'b0;
        chk("ce_rel", 32'(vld4), 0);
        wait_vld4("ce3");
        chk("ce3_sw", 32'(sw4), 3);

`ifdef DATA_PIPE_ARB_TIMEOUT_EN
        // path 3 stalls: watchdog releases after 16 lock cycles
        n = 0;
        while (vld4 && n < 40) begin
            chk("to_quiet", 32'(to4), 0);
            step();
            n++;
        end
        chk("to_cycles", 32'(n), 16);
        chk("to_pulse", 32'(to4), 1);
        step();
        chk("to_pulse_end", 32'(to4), 0);
`else
        chk("to_tied", 32'(to4), 0);
        beat4(4'b1000);
        chk("p3_rel", 32'(vld4), 0);
        chk("to_tied2", 32'(to4), 0);
`endif
        wait_vld4("wrap4");
        chk("wrap4_sw", 32'(sw4), 0);
        beat4(4'b1111);

        // NUM=5: pointer 4 wraps to 0, never past 4
        req5 = 5'b01000;
        wait_vld5("n5a");
        chk("n5a_sw", 32'(sw5), 3);
        beat5();
        req5 = 5'b00011;
        wait_vld5("n5b");
        chk("n5b_sw", 32'(sw5), 0);
        chk("n5b_prio", 32'(prio5), 32'h1);
        beat5();
        wait_vld5("n5c");
        chk("n5c_sw", 32'(sw5), 1);
        beat5();
        req5 = 5'b10000;
        wait_vld5("n5d");
        chk("n5d_sw", 32'(sw5), 4);
        chk("n5d_prio", 32'(prio5), 32'h10);
        beat5();
        req5 = 5'b11111;
        wait_vld5("n5e");
        chk("n5e_sw", 32'(sw5), 0);
        beat5();
        req5 = '0;
        repeat (4) step();
        chk("n5_idle", 32'(busy5), 0);
        chk("n5_to", 32'(to5), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
